// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter that shares one 4-input datapath mux between four
// requesters (e.g. PC, ALU, memory, register-file writeback). It produces a
// registered one-hot grant and the matching 2-bit mux select. One dead
// turnaround cycle is inserted between owners.
//
// Optional feature (macro ARB_TIMEOUT_EN): an owner that has held the bus for
// MAX_HOLD or more cycles is forced off when another requester is waiting.
// A one-cycle preempt pulse marks the forced release.
//
// Parameters:
//   MAX_HOLD : owned cycles before a forced release (ARB_TIMEOUT_EN only), >= 1
//   CW       : hold counter width, 2**CW > MAX_HOLD
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   req     in   [3:0] level request lines, held for the whole ownership
//   gnt     out  [3:0] registered one-hot grant, zero when no owner
//   sel     out  [1:0] registered mux select = current or most recent owner
//   busy    out  registered, high while any gnt bit is high
//   preempt out  registered one-cycle forced-release pulse (ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic       preempt
`endif
);

    // Parameter sanity check, evaluated at elaboration.
    if (MAX_HOLD < 1 || (64'd1 << CW) <= 64'(MAX_HOLD)) begin : g_param_bad
        $error("rr_mux_arbiter: need MAX_HOLD >= 1 and 2**CW > MAX_HOLD");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic [1:0] r_last;
    logic       r_busy;

    logic       w_any;
    logic [1:0] w_win;
    logic       w_owner_req;

    // Round-robin pick: the search order is last+1, last+2, last+3, last.
    // The loop runs from the lowest priority (offset 4 == last itself) to the
    // highest (offset 1) so the final matching assignment wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign w_any       = |req;
    assign w_win       = rr_pick(req, r_last);
    assign w_owner_req = req[r_last];

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [CW-1:0] r_cnt;
    logic          r_preempt;
    logic          w_others;
    logic          w_timeout;

    // Any requester other than the current owner is waiting.
    assign w_others  = |(req & ~(4'b0001 << r_last));
    assign w_timeout = (r_cnt >= HOLD_LIM) && w_others;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
            // Requester 0 gets top priority after reset.
            r_last  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_preempt <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_preempt <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_TURN: begin
                    if (w_any) begin
                        r_state <= ST_OWN;
                        r_gnt   <= 4'b0001 << w_win;
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= CW'(1);
`endif
                    end else begin
                        // sel keeps the most recent owner while idle.
                        r_state <= ST_IDLE;
                    end
                end

                ST_OWN: begin
                    if (!w_owner_req) begin
                        // Voluntary release; sel stays put through turnaround.
                        r_state <= ST_TURN;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state   <= ST_TURN;
                        r_gnt     <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_preempt <= 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign preempt = r_preempt;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
`ifdef ARB_TIMEOUT_EN
    logic       preempt;
`endif

    int n_vec;
    int n_err;

    rr_mux_arbiter #(
        .MAX_HOLD(4),
        .CW      (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .preempt(preempt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb);
        n_vec++;
        assert ({gnt, sel, busy} === {eg, es, eb})
        else begin
            n_err++;
            $error("FAIL %s: gnt/sel/busy got %b/%0d/%b expected %b/%0d/%b",
                   tag, gnt, sel, busy, eg, es, eb);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic chk_pre(input string tag, input logic ep);
        n_vec++;
        assert (preempt === ep)
        else begin
            n_err++;
            $error("FAIL %s: preempt got %b expected %b", tag, preempt, ep);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // Single requester, grant latency, release and turnaround.
        req = 4'b0001; tick(); chk("t1_grant", 4'b0001, 2'd0, 1'b1);
        tick();                chk("t1_hold",  4'b0001, 2'd0, 1'b1);
        req = 4'b0000; tick(); chk("t1_turn",  4'b0000, 2'd0, 1'b0);
        tick();                chk("t1_idle",  4'b0000, 2'd0, 1'b0);

        // Full rotation 0,1,2,3,0 with all requesting.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1111; tick(); chk("rr_g0",  4'b0001, 2'd0, 1'b1);
        req = 4'b1110; tick(); chk("rr_t0",  4'b0000, 2'd0, 1'b0);
        req = 4'b1111; tick(); chk("rr_g1",  4'b0010, 2'd1, 1'b1);
        req = 4'b1101; tick(); chk("rr_t1",  4'b0000, 2'd1, 1'b0);
        req = 4'b1111; tick(); chk("rr_g2",  4'b0100, 2'd2, 1'b1);
        req = 4'b1011; tick(); chk("rr_t2",  4'b0000, 2'd2, 1'b0);
        req = 4'b1111; tick(); chk("rr_g3",  4'b1000, 2'd3, 1'b1);
        req = 4'b0111; tick(); chk("rr_t3",  4'b0000, 2'd3, 1'b0);
        req = 4'b1111; tick(); chk("rr_g0b", 4'b0001, 2'd0, 1'b1);

        // Non-owner changes ignored while owning.
        req = 4'b0011; tick(); chk("own_ignore", 4'b0001, 2'd0, 1'b1);

        // Wrap 3 -> 0, then 0 -> 2 with req 0101.
        req = 4'b1110; tick(); chk("w_t0",   4'b0000, 2'd0, 1'b0);
        req = 4'b1000; tick(); chk("w_g3",   4'b1000, 2'd3, 1'b1);
        req = 4'b0101; tick(); chk("w_t3",   4'b0000, 2'd3, 1'b0);
        tick();                chk("w_wrap0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0100; tick(); chk("w_t0b",  4'b0000, 2'd0, 1'b0);
        req = 4'b0101; tick(); chk("w_g2",   4'b0100, 2'd2, 1'b1);

        // Lone requester regains ownership after release.
        req = 4'b0000; tick(); chk("l_t2",   4'b0000, 2'd2, 1'b0);
        tick();                chk("l_idle", 4'b0000, 2'd2, 1'b0);
        req = 4'b0010; tick(); chk("l_g1",   4'b0010, 2'd1, 1'b1);
        req = 4'b0000; tick(); chk("l_t1",   4'b0000, 2'd1, 1'b0);
        req = 4'b0010; tick(); chk("l_g1b",  4'b0010, 2'd1, 1'b1);

        // Reset mid-ownership, then priority restarts from requester 0.
        req = 4'b0100; tick(); chk("m_t1",   4'b0000, 2'd1, 1'b0);
        tick();                chk("m_g2",   4'b0100, 2'd2, 1'b1);
        reset = 1'b1;  tick(); chk("m_rst",  4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        req = 4'b1100; tick(); chk("m_g2b",  4'b0100, 2'd2, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD=4 owned cycles with a competitor.
        reset = 1'b1; req = 4'b0000; tick(); reset = 1'b0;
        req = 4'b0001; tick(); chk("p_g0", 4'b0001, 2'd0, 1'b1); chk_pre("p_pre1", 1'b0);
        req = 4'b0101;
        tick(); chk("p_h2", 4'b0001, 2'd0, 1'b1);
        tick(); chk("p_h3", 4'b0001, 2'd0, 1'b1);
        tick(); chk("p_h4", 4'b0001, 2'd0, 1'b1); chk_pre("p_pre4", 1'b0);
        tick(); chk("p_rel", 4'b0000, 2'd0, 1'b0); chk_pre("p_pulse", 1'b1);
        tick(); chk("p_g2", 4'b0100, 2'd2, 1'b1); chk_pre("p_pre_off", 1'b0);

        // No competitor: ownership continues past MAX_HOLD.
        reset = 1'b1; req = 4'b0000; tick(); reset = 1'b0;
        req = 4'b0001; tick(); chk("n_g0", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("n_hold", 4'b0001, 2'd0, 1'b1);
            chk_pre("n_pre", 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
